// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer
//
// Ports:
//   clk, rst (sync, active-low)
//   mem_ready                 memory completes the current request at this edge
//   halt_in, is_load, is_store, reg_write, jump_taken   decoded control inputs
//   mem_req, mem_we, mem_addr_sel, ir_load             memory port / IR control
//   reg_we, pc_inc, pc_load                            one-cycle writeback strobes
//   halted, bus_error, state, retired                  status and debug
module instr_sequencer #(
    parameter int WAIT_LIMIT = 255,
    parameter int COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_ready,
    input  logic               halt_in,
    input  logic               is_load,
    input  logic               is_store,
    input  logic               reg_write,
    input  logic               jump_taken,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               ir_load,
    output logic               reg_we,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               halted,
    output logic               bus_error,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] retired
);

    localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    // Value of the counter during the WAIT_LIMIT-th consecutive wait cycle.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALTED    = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [COUNT_W-1:0]  retired_q, retired_d;
    logic                bus_error_q, bus_error_d;
    logic                req_raw;
    logic                waiting;

    always_comb begin
        state_d      = state_q;
        retired_d    = retired_q;
        bus_error_d  = bus_error_q;
        req_raw      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        reg_we       = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;

        case (state_q)
            S_FETCH: begin
                req_raw = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = halt_in ? S_HALTED : S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = (is_load || is_store) ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                req_raw      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = is_store;
                if (mem_ready) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                reg_we    = reg_write;
                pc_load   = jump_taken;
                pc_inc    = !jump_taken;
                retired_d = retired_q + 1'b1;
                state_d   = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase

        // Counts consecutive stalled cycles of the current request; any cycle
        // without a stalled request (including the completing one) clears it,
        // so every FETCH/MEMORY entry starts from zero.
        waiting = req_raw && !mem_ready;
        wait_d  = waiting ? wait_q + 1'b1 : '0;
        if ((WAIT_LIMIT != 0) && waiting && (wait_q == WAIT_LAST)) begin
            state_d     = S_HALTED;
            bus_error_d = 1'b1;
        end

        mem_req = req_raw;
        if (!rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_load      = 1'b0;
            reg_we       = 1'b0;
            pc_inc       = 1'b0;
            pc_load      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            retired_q   <= retired_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign halted    = (state_q == S_HALTED);
    assign bus_error = bus_error_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
module tb_instr_sequencer;
    localparam int L  = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_ready = 1'b0, halt_in = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic reg_write = 1'b0, jump_taken = 1'b0;
    logic mem_req, mem_we, mem_addr_sel, ir_load, reg_we, pc_inc, pc_load;
    logic halted, bus_error;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic [11:0]   obs;

    int n_checks = 0;
    int n_pass   = 0;
    logic [11:0]   exp_q[$];
    bit            rdy_q[$];
    logic [CW-1:0] exp_retired = '0;
    bit            exp_berr = 1'b0;

    instr_sequencer #(.WAIT_LIMIT(L), .COUNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mem_ready(mem_ready), .halt_in(halt_in),
        .is_load(is_load), .is_store(is_store), .reg_write(reg_write),
        .jump_taken(jump_taken), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .reg_we(reg_we),
        .pc_inc(pc_inc), .pc_load(pc_load), .halted(halted),
        .bus_error(bus_error), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, mem_we, mem_addr_sel, ir_load, reg_we,
                  pc_inc, pc_load, halted, bus_error};

    function automatic logic [11:0] mk(input logic [2:0] st, input bit req, we, sel,
                                       irl, rwe, pinc, pld, hlt, berr);
        return {st, req, we, sel, irl, rwe, pinc, pld, hlt, berr};
    endfunction

    task automatic push(input logic [11:0] e, input bit r);
        exp_q.push_back(e);
        rdy_q.push_back(r);
    endtask

    task automatic push_halted(input int n);
        for (int i = 0; i < n; i++) push(mk(3'd5, 0, 0, 0, 0, 0, 0, 0, 1, exp_berr), 1'b0);
    endtask

    // A memory phase with w wait cycles; w >= L means the request times out.
    task automatic push_mem(input logic [2:0] st, input bit we, input bit sel,
                            input int w, output bit timeout);
        int n;
        bit r;
        timeout = (w >= L);
        n = timeout ? L : w + 1;
        for (int i = 0; i < n; i++) begin
            r = !timeout && (i == n - 1);
            push(mk(st, 1, we, sel, (st == 3'd0) && r, 0, 0, 0, 0, exp_berr), r);
        end
        if (timeout) exp_berr = 1'b1;
    endtask

    task automatic build_instr(input bit ld, st, rw, jp, hl, input int fw, input int mw);
        bit to;
        is_load = ld; is_store = st; reg_write = rw; jump_taken = jp; halt_in = hl;
        push_mem(3'd0, 0, 0, fw, to);
        if (to) begin push_halted(1); return; end
        push(mk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, exp_berr), 1'b0);
        if (hl) begin push_halted(1); return; end
        push(mk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, exp_berr), 1'b0);
        if (ld || st) begin
            push_mem(3'd3, st, 1, mw, to);
            if (to) begin push_halted(1); return; end
        end
        push(mk(3'd4, 0, 0, 0, 0, rw, !jp, jp, 0, exp_berr), 1'b0);
        exp_retired = exp_retired + 1'b1;
    endtask

    // Entered and left just after a falling edge.
    task automatic run_queue(input string name, input int max_cycles);
        logic [11:0] e;
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < max_cycles) begin
            e = exp_q.pop_front();
            mem_ready = rdy_q.pop_front();
            #1;
            n_checks++;
            if (obs !== e) $display("FAIL %s cyc%0d: got %b want %b", name, i, obs, e);
            else n_pass++;
            i++;
            @(negedge clk);
        end
    endtask

    task automatic check_retired(input string name);
        n_checks++;
        if (retired !== exp_retired)
            $display("FAIL %s retired: got %0d want %0d", name, retired, exp_retired);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (obs[8:2] !== 7'b0) $display("FAIL reset_strobes: got %b want 0000000", obs[8:2]);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (obs !== mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0))
            $display("FAIL reset_state: got %b want %b", obs, mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        else n_pass++;
        n_checks++;
        if (retired !== '0) $display("FAIL reset_retired: got %0d want 0", retired);
        else n_pass++;
        exp_retired = '0;
        exp_berr = 1'b0;
        exp_q.delete();
        rdy_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_add();
        build_instr(0, 0, 1, 0, 0, 0, 0);
        run_queue("add", 100);
        check_retired("add");
    endtask

    task automatic test_load_wait();
        build_instr(1, 0, 1, 0, 0, 0, 3);
        run_queue("load_wait", 100);
        check_retired("load_wait");
    endtask

    task automatic test_store_jump();
        build_instr(0, 1, 0, 0, 0, 1, 0);
        run_queue("store", 100);
        build_instr(0, 0, 0, 1, 0, 0, 0);
        run_queue("jump", 100);
        check_retired("store_jump");
    endtask

    task automatic test_halt();
        build_instr(0, 1, 1, 0, 1, 0, 0);
        push_halted(20);
        run_queue("halt", 100);
        check_retired("halt");
        test_reset();
    endtask

    task automatic test_timeout();
        build_instr(0, 0, 1, 0, 0, L, 0);
        push_halted(3);
        run_queue("timeout", 100);
        test_reset();
        build_instr(0, 0, 1, 0, 0, L - 1, 0);
        run_queue("ready_wins", 100);
        check_retired("ready_wins");
    endtask

    task automatic test_back_to_back_wrap();
        test_reset();
        for (int k = 0; k < 16; k++) begin
            build_instr(k % 3 == 1, k % 5 == 2, k % 2 == 0, k % 4 == 3, 0,
                        int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            run_queue("b2b", 100);
            check_retired("b2b");
        end
        n_checks++;
        if (retired !== '0) $display("FAIL wrap: got %0d want 0", retired);
        else n_pass++;
    endtask

    task automatic test_reset_mid_memory();
        build_instr(0, 0, 1, 0, 0, 0, 0);
        run_queue("pre_abort", 100);
        check_retired("pre_abort");
        build_instr(1, 0, 1, 0, 0, 0, 3);
        run_queue("abort", 4);
        test_reset();
        build_instr(0, 0, 1, 1, 0, 0, 0);
        run_queue("post_abort", 100);
        check_retired("post_abort");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_load_wait();
        test_store_jump();
        test_halt();
        test_timeout();
        test_back_to_back_wrap();
        test_reset_mid_memory();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction sequencer that drives the processor datapath through fetch, decode, execute, memory and writeback phases. It shares the single memory port between instruction fetch and load/store data access, issues one-cycle register-write and PC-update strobes, and detects halt and bus timeout conditions. It sits between the instruction decoder, which supplies the decoded control signals, and the datapath and memory interface.

## Interface
- WAIT_LIMIT, 255: maximum consecutive wait cycles per memory request before bus error; 0 disables the timeout.
- COUNT_W, 32: width of the retired-instruction counter.

- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- mem_ready  in  1  memory completes the current request at this edge. Ignored while mem_req=0.
- halt_in  in  1  decoder halt (hlt or invalid opcode). Sampled in DECODE only.
- is_load  in  1  the decoder selects memory as the register write source. Sampled in EXECUTE.
- is_store  in  1  the decoder selects a memory write source. Sampled in EXECUTE and MEMORY.
- reg_write  in  1  the decoder selects any register write source. Sampled in WRITEBACK.
- jump_taken  in  1  a jump source is selected and its condition is met. Sampled in WRITEBACK.
- mem_req  out  1  memory request is active.
- mem_we  out  1  1 = write (store), 0 = read.
- mem_addr_sel  out  1  0 = PC, 1 = data address.
- ir_load  out  1  instruction register captures memory read data at this edge.
- reg_we  out  1  register file write strobe.
- pc_inc  out  1  PC advances to the next instruction.
- pc_load  out  1  PC loads the jump target.
- halted  out  1  sequencer is in HALTED.
- bus_error  out  1  sticky; a memory timeout caused the halt.
- state  out  3  current state encoding, for debug.
- retired  out  COUNT_W  count of completed instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALTED=5. Codes 6 and 7 are illegal and go to HALTED on the next edge.
- All strobes are combinational from the state and are forced to 0 while rst=0.
- FETCH
  - Drives mem_req=1, mem_we=0, mem_addr_sel=0.
  - With mem_ready=1: ir_load=1 in that cycle, then go to DECODE.
- DECODE
  - One cycle.
  - halt_in=1: go to HALTED. halt_in has priority over every other decoded signal.
  - Otherwise go to EXECUTE.
- EXECUTE
  - One cycle.
  - is_load or is_store: go to MEMORY.
  - Otherwise go to WRITEBACK.
- MEMORY
  - Drives mem_req=1, mem_addr_sel=1, mem_we=is_store.
  - With mem_ready=1: go to WRITEBACK.
- WRITEBACK
  - One cycle: reg_we=reg_write, pc_load=jump_taken, pc_inc=!jump_taken.
  - retired increments, wrapping at 2^COUNT_W.
  - Go to FETCH.
- HALTED
  - All strobes 0, halted=1.
  - Leaves only through reset.
  - An instruction that halts is not counted in retired.
- Wait counter
  - Cleared on entry to FETCH or MEMORY.
  - Increments on each edge where mem_req=1 and mem_ready=0.
  - With WAIT_LIMIT≠0, the edge completing the WAIT_LIMIT-th wait cycle goes to HALTED and sets bus_error=1.
  - If mem_ready=1 on that same cycle, the transfer wins and no error is raised.
- mem_we and mem_addr_sel stay stable for the whole request, from the first cycle until the mem_ready edge.

## Timing
- Reset
  - rst=0 at any edge: state=FETCH, retired=0, wait counter=0, bus_error=0, halted=0.
  - All strobes are 0 while rst=0.
  - An in-flight request is abandoned; memory must tolerate mem_req dropping without mem_ready.
- First mem_req=1 appears in the first cycle after rst returns to 1.
- Latency with zero-wait memory:
  - Non-memory instruction: 4 cycles (F, D, E, W).
  - Load/store: 5 cycles (F, D, E, M, W).
  - Each wait cycle adds 1.
- Per instruction: exactly one ir_load pulse, and at most one pulse each of reg_we, pc_inc and pc_load.
- pc_inc and pc_load are mutually exclusive.

## Test plan
- Reset, then zero-wait memory with an add instruction (reg_write=1, no load/store): state sequence 0,1,2,4,0. ir_load pulses in cycle 1 after reset release; reg_we and pc_inc pulse in cycle 4; retired=1.
- Load with mem_ready delayed 3 cycles in MEMORY: mem_req=1, mem_addr_sel=1, mem_we=0 held for 4 cycles. Total instruction 8 cycles; reg_we pulses once.
- Store followed by taken jump: MEMORY shows mem_we=1. On the next instruction with jump_taken=1, WRITEBACK shows pc_load=1, pc_inc=0, reg_we=0.
- halt_in=1 together with is_store=1 in DECODE: HALTED next edge, halted=1, no mem_we pulse, retired unchanged. The state holds for 20 cycles; the next rst=0 returns to FETCH.
- WAIT_LIMIT=4 with mem_ready held low in FETCH: HALTED after 4 wait cycles, bus_error=1. Repeating with mem_ready=1 on the 4th cycle reaches DECODE with bus_error=0.
- COUNT_W=4: 16 retired instructions wrap retired to 0. Asserting rst=0 mid-MEMORY clears retired and returns state to 0.
